// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// The master issues one request at a time and holds every field stable
// until the memory acknowledges it.
interface mem_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_stage_access.sv
// MEM-stage memory access unit.
// Converts the registered EX/MEM memory controls into data-memory bus
// transactions, formats load data for MEM/WB and stalls the front of the
// pipeline while a transaction is outstanding.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that has not
// been acknowledged within TIMEOUT_CYCLES cycles and pulse BusErr_o.
module mem_stage_access #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic [2:0]         Load_i,
    input  logic [1:0]         Store_i,
    input  logic [31:0]        Addr_i,
    input  logic [31:0]        MemWriteData_i,
    mem_stage_if.master        dm,
    output logic [31:0]        MemReadData_o,
    output logic               MEM_Stall,
    output logic               AddrErr_o,
    output logic               BusErr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
    localparam logic [1:0] ST_SB  = 2'b01;
    localparam logic [1:0] ST_SH  = 2'b10;

    state_t      state_q, state_d;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  ld_q;
    logic [1:0]  lo_q;
    logic [31:0] rdata_q;
    logic        adderr_q, adderr_d;
    logic        latch;
    logic        rd_cap;
    logic        access;
    logic        mis;

    // Size check: a write uses the store type, a read uses the load type.
    function automatic logic misaligned(input logic is_wr, input logic [2:0] ld,
                                        input logic [1:0] st, input logic [1:0] lo);
        logic r;
        if (is_wr) begin
            case (st)
                ST_SB:   r = 1'b0;
                ST_SH:   r = lo[0];
                default: r = |lo;
            endcase
        end else begin
            case (ld)
                LD_LB, LD_LBU: r = 1'b0;
                LD_LH, LD_LHU: r = lo[0];
                default:       r = |lo;
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] lo);
        logic [3:0] be;
        case (st)
            ST_SB:   be = 4'b0001 << lo;
            ST_SH:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] d);
        logic [31:0] w;
        case (st)
            ST_SB:   w = {4{d[7:0]}};
            ST_SH:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] format_load(input logic [2:0] ld, input logic [1:0] lo,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (ld)
            LD_LB:   r = {{24{b[7]}}, b};
            LD_LBU:  r = {24'd0, b};
            LD_LH:   r = {{16{h[15]}}, h};
            LD_LHU:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // A simultaneous read and write is treated as a write only.
    assign access = MemRead_i | MemWrite_i;
    assign mis    = misaligned(MemWrite_i, Load_i, Store_i, Addr_i[1:0]);

`ifdef MEM_TIMEOUT_EN
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                buserr_q, buserr_d;
`endif

    // Next-state, stall and capture strobes.
    always_comb begin
        state_d   = state_q;
        MEM_Stall = 1'b0;
        latch     = 1'b0;
        rd_cap    = 1'b0;
        adderr_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        buserr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (mis) begin
                        adderr_d = 1'b1;
                    end else begin
                        MEM_Stall = 1'b1;
                        latch     = 1'b1;
                        state_d   = REQ;
`ifdef MEM_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            REQ: begin
                MEM_Stall = 1'b1;
                if (dm.dm_ack) begin
                    rd_cap  = ~we_q;
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    buserr_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and error pulse registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            adderr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adderr_q <= adderr_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout counter and bus-error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            buserr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            buserr_q <= buserr_d;
        end
    end
    assign BusErr_o = buserr_q;
`else
    assign BusErr_o = 1'b0;
`endif

    // Bus fields are latched on request entry and held stable through REQ.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            ld_q    <= 3'd0;
            lo_q    <= 2'd0;
        end else if (latch) begin
            we_q    <= MemWrite_i;
            be_q    <= MemWrite_i ? store_be(Store_i, Addr_i[1:0]) : 4'b1111;
            addr_q  <= {Addr_i[31:2], 2'b00};
            wdata_q <= store_wdata(Store_i, MemWriteData_i);
            ld_q    <= Load_i;
            lo_q    <= Addr_i[1:0];
        end
    end

    // Load result only changes when a read is acknowledged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'd0;
        end else if (rd_cap) begin
            rdata_q <= format_load(ld_q, lo_q, dm.dm_rdata);
        end
    end

    assign dm.dm_req    = (state_q == REQ);
    assign dm.dm_we     = we_q;
    assign dm.dm_addr   = addr_q;
    assign dm.dm_be     = be_q;
    assign dm.dm_wdata  = wdata_q;
    assign MemReadData_o = rdata_q;
    assign AddrErr_o     = adderr_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Randomized self-checking bench for mem_stage_access with a behavioural
// memory responder and a reference model of alignment, lanes and load format.
module tb_mem_stage_access;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [2:0]  Load_i = 3'd0;
    logic [1:0]  Store_i = 2'd0;
    logic [31:0] Addr_i = 32'd0;
    logic [31:0] MemWriteData_i = 32'd0;
    logic [31:0] MemReadData_o;
    logic        MEM_Stall;
    logic        AddrErr_o;
    logic        BusErr_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_rd = 32'd0;

    mem_stage_if bus ();

    mem_stage_access #(.TIMEOUT_CYCLES(T), .TO_CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .Load_i         (Load_i),
        .Store_i        (Store_i),
        .Addr_i         (Addr_i),
        .MemWriteData_i (MemWriteData_i),
        .dm             (bus),
        .MemReadData_o  (MemReadData_o),
        .MEM_Stall      (MEM_Stall),
        .AddrErr_o      (AddrErr_o),
        .BusErr_o       (BusErr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input bit wr, input logic [2:0] ld, input logic [1:0] st);
        if (wr) return (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
        return (ld == 3'd1 || ld == 3'd2) ? 1 : (ld == 3'd3 || ld == 3'd4) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] st, input logic [31:0] a);
        int sz;
        sz = access_size(1'b1, 3'd0, st);
        return 4'((1 << sz) - 1) << (a % 4);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] st, input logic [31:0] d);
        if (st == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
        if (st == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (ld)
            3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    // Presents one EX/MEM instruction, plays the memory (ack after `waits`
    // request cycles) and checks the whole transaction. Entered and left
    // just after a falling edge.
    task automatic do_access(input string tag, input bit rd, input bit wr,
                             input logic [2:0] ld, input logic [1:0] st,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int waits, input logic [31:0] rword);
        bit acc, mis, tmo, done, saw_req, saw_bus;
        int stalls, reqc, cycles, exp_stalls;
        acc = rd | wr;
        mis = acc && ((addr % access_size(wr, ld, st)) != 0);
`ifdef MEM_TIMEOUT_EN
        tmo = acc && !mis && (waits >= T);
`else
        tmo = 1'b0;
`endif
        exp_stalls = (!acc || mis) ? 0 : tmo ? (T + 1) : (waits + 2);
        MemRead_i = rd; MemWrite_i = wr; Load_i = ld; Store_i = st;
        Addr_i = addr; MemWriteData_i = wd;
        stalls = 0; reqc = 0; cycles = 0; done = 0; saw_req = 0; saw_bus = 0;
        while (!done && cycles < 200) begin
            #1;
            if (bus.dm_req) begin
                saw_req = 1;
                reqc++;
                if (reqc == 1) begin
                    check({tag, ".addr"}, bus.dm_addr, addr & 32'hFFFF_FFFC);
                    check({tag, ".we"}, 32'(bus.dm_we), 32'(wr));
                    check({tag, ".be"}, 32'(bus.dm_be), 32'(wr ? ref_be(st, addr) : 4'hF));
                    if (wr) check({tag, ".wdata"}, bus.dm_wdata, ref_wdata(st, wd));
                end
                if (reqc > waits) begin
                    bus.dm_ack = 1'b1;
                    bus.dm_rdata = rword;
                end
            end
            if (BusErr_o) saw_bus = 1;
            if (MEM_Stall) stalls++;
            else done = 1;
            @(posedge clk);
            @(negedge clk);
            bus.dm_ack = 1'b0;
            bus.dm_rdata = $urandom;
            cycles++;
        end
        if (!done) check({tag, ".cycle_bound"}, 32'(cycles), 32'd0);
        #1;
        check({tag, ".stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, ".req_seen"}, 32'(saw_req), 32'(acc && !mis));
        check({tag, ".adderr"}, 32'(AddrErr_o), 32'(mis));
        check({tag, ".buserr"}, 32'(saw_bus), 32'(tmo));
        if (rd && !wr && acc && !mis && !tmo) last_rd = ref_load(ld, addr, rword);
        check({tag, ".rdata"}, MemReadData_o, last_rd);
    endtask

    task automatic idle_cycle();
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.dm_ack = 1'b0;
        bus.dm_rdata = 32'd0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst.req", 32'(bus.dm_req), 32'd0);
        check("rst.be", 32'(bus.dm_be), 32'd0);
        check("rst.addr", bus.dm_addr, 32'd0);
        check("rst.rdata", MemReadData_o, 32'd0);
        check("rst.stall", 32'(MEM_Stall), 32'd0);
        check("rst.buserr", 32'(BusErr_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_access("lw10", 1, 0, 3'd0, 2'd0, 32'h10, 32'd0, 0, 32'hDEAD_BEEF);
        check("lw10.value", MemReadData_o, 32'hDEAD_BEEF);
        do_access("lb13", 1, 0, 3'd1, 2'd0, 32'h13, 32'd0, 0, 32'h80FF_0000);
        check("lb13.value", MemReadData_o, 32'hFFFF_FF80);
        do_access("lbu13", 1, 0, 3'd2, 2'd0, 32'h13, 32'd0, 1, 32'h80FF_0000);
        check("lbu13.value", MemReadData_o, 32'h0000_0080);
        do_access("lhu12", 1, 0, 3'd4, 2'd0, 32'h12, 32'd0, 2, 32'h80FF_0000);
        check("lhu12.value", MemReadData_o, 32'h0000_80FF);
        do_access("sb21", 0, 1, 3'd0, 2'd1, 32'h21, 32'h0000_00AB, 0, 32'h1234_5678);
        check("sb21.hold", MemReadData_o, 32'h0000_80FF);
        do_access("rw_both", 1, 1, 3'd0, 2'd2, 32'h32, 32'h0000_BEEF, 1, 32'h5555_AAAA);
        do_access("lw22", 1, 0, 3'd0, 2'd0, 32'h22, 32'd0, 0, 32'h0);
        idle_cycle();
        #1;
        check("lw22.pulse_end", 32'(AddrErr_o), 32'd0);
        @(negedge clk);

        // Reset while a request is outstanding.
        MemRead_i = 1'b1; MemWrite_i = 1'b0; Load_i = 3'd0; Addr_i = 32'h40;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #1;
        check("midrst.req_before", 32'(bus.dm_req), 32'd1);
        rst = 1'b0;
        MemRead_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("midrst.req", 32'(bus.dm_req), 32'd0);
        check("midrst.we", 32'(bus.dm_we), 32'd0);
        check("midrst.be", 32'(bus.dm_be), 32'd0);
        check("midrst.addr", bus.dm_addr, 32'd0);
        check("midrst.wdata", bus.dm_wdata, 32'd0);
        check("midrst.rdata", MemReadData_o, 32'd0);
        check("midrst.stall", 32'(MEM_Stall), 32'd0);
        last_rd = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        do_access("after_rst", 1, 0, 3'd3, 2'd0, 32'h46, 32'd0, 0, 32'h8001_7FFF);

        // Long wait: completes normally, or aborts when the timeout is built in.
        do_access("longwait", 1, 0, 3'd0, 2'd0, 32'h80, 32'd0, 20, 32'hCAFE_F00D);
        do_access("edgewait", 1, 0, 3'd0, 2'd0, 32'h84, 32'd0, T - 1, 32'h0BAD_F00D);

        for (int i = 0; i < 150; i++) begin
            bit rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 2) == 0);
            do_access("rand", rd, wr, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom_range(0, 4), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
